// File: rtl/sn_to_bn_if.sv
// Bundles the stochastic-stream inputs and decoded-value outputs of the sn->bn decoder.
// Latency: none, wiring only.
// Backpressure: none. Streams are framed by i_isgen, and o_valid is a one-cycle pulse.
interface sn_to_bn_if #(
  parameter int NUM_BIT = 8,
  parameter int DIM     = 10
);
  logic                            i_isgen;
  logic [DIM-1:0]                  i_sn_bit;
  logic [DIM-1:0][NUM_BIT-1:0]     o_x_bn;
  logic                            o_valid;
  logic                            o_trunc;
  logic                            o_busy;

  // Stream source side: the generator or the testbench.
  modport master (
    output i_isgen,
    output i_sn_bit,
    input  o_x_bn,
    input  o_valid,
    input  o_trunc,
    input  o_busy
  );

  // Decoder side.
  modport slave (
    input  i_isgen,
    input  i_sn_bit,
    output o_x_bn,
    output o_valid,
    output o_trunc,
    output o_busy
  );
endinterface

// File: rtl/sn_to_bn_decoder.sv
// Counts ones per lane over a 2^NUM_BIT-sample window framed by i_isgen and emits binary values.
// Latency: o_x_bn/o_valid 1 cycle after the first low i_isgen sample or after the last full-window sample.
// Backpressure: none. Input is sampled every i_isgen-high cycle, and o_x_bn is held until the next o_valid.
module sn_to_bn_decoder #(
  parameter int NUM_BIT = 8,
  parameter int DIM     = 10
) (
  input  logic        i_clk_sn2bn,
  input  logic        i_rst_n_sn2bn,
  sn_to_bn_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // len value just before the final sample of a full window
  localparam logic [NUM_BIT:0] LEN_LAST = (NUM_BIT+1)'((1 << NUM_BIT) - 1);

  logic [1:0]                  r_state;
  logic [DIM-1:0][NUM_BIT-1:0] r_cnt;
  logic [NUM_BIT:0]            r_len;
  logic [DIM-1:0][NUM_BIT-1:0] r_x_bn;
  logic                        r_valid;
  logic                        r_trunc;
  logic [DIM-1:0][NUM_BIT-1:0] w_cnt_nxt;

  // Per-lane saturating increment. Saturation only matters for an all-ones full window.
  always_comb begin
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < DIM; i++) begin
      if (bus.i_sn_bit[i] && !(&r_cnt[i])) begin
        w_cnt_nxt[i] = r_cnt[i] + NUM_BIT'(1);
      end
    end
  end

  // Window FSM: accumulate while i_isgen is high, then publish on window end or on a full window.
  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_x_bn  <= '0;
      r_valid <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_isgen) begin
            // The first high sample already counts, which restarts each lane from its bit.
            for (int i = 0; i < DIM; i++) begin
              r_cnt[i] <= NUM_BIT'(bus.i_sn_bit[i]);
            end
            r_len   <= (NUM_BIT+1)'(1);
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (bus.i_isgen) begin
            r_cnt <= w_cnt_nxt;
            r_len <= r_len + (NUM_BIT+1)'(1);
            if (r_len == LEN_LAST) begin
              r_x_bn  <= w_cnt_nxt;
              r_valid <= 1'b1;
              r_trunc <= 1'b0;
              r_state <= ST_HOLD;
            end
          end else begin
            // The window closed early. The low edge itself is not a sample.
            r_x_bn  <= r_cnt;
            r_valid <= 1'b1;
            r_trunc <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!bus.i_isgen) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_x_bn  = r_x_bn;
  assign bus.o_valid = r_valid;
  assign bus.o_trunc = r_trunc;
  assign bus.o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sn_to_bn_decoder.sv
// Bench for sn_to_bn_decoder: window table plus saturation/reset sequences, scoreboard on o_valid.
// Latency: expectations are queued when a window is driven and popped on each o_valid.
// Backpressure: none. The monitor samples on the falling edge.
module tb_sn_to_bn_decoder;
  localparam int NB  = 8;
  localparam int DIM = 10;

  typedef logic [DIM-1:0][NB-1:0] lanes_t;
  typedef struct {
    int     n_hi;
    int     mode;       // 0: encoded from x, 1: all ones, 2: lane 3 alternating
    lanes_t x;
    lanes_t exp_x;
    logic   exp_trunc;
  } vec_t;
  typedef struct {
    lanes_t x;
    logic   trunc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sn_to_bn_if #(.NUM_BIT(NB), .DIM(DIM)) bus();

  sn_to_bn_decoder #(.NUM_BIT(NB), .DIM(DIM)) dut (
    .i_clk_sn2bn   (clk),
    .i_rst_n_sn2bn (rst_n),
    .bus           (bus)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  exp_t   sb_q[$];
  exp_t   sb_e;
  lanes_t prev_x     = '0;
  logic   prev_trunc = 1'b0;
  logic   prev_valid = 1'b0;

  task automatic chk(input string name, input lanes_t act, input lanes_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic lanes_t splat(input logic [NB-1:0] v);
    lanes_t r;
    for (int i = 0; i < DIM; i++) r[i] = v;
    return r;
  endfunction

  function automatic logic [NB-1:0] rev8(input logic [NB-1:0] v);
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) r[b] = v[NB-1-b];
    return r;
  endfunction

  // Generator-like encoding: bit-reversed time compared against the value, so cycle 255 is always 0.
  function automatic logic [DIM-1:0] gen_bits(input int mode, input int t, input lanes_t x);
    logic [DIM-1:0] b;
    logic [NB-1:0]  tr;
    tr = rev8(NB'(t));
    b  = '0;
    for (int i = 0; i < DIM; i++) begin
      case (mode)
        0:       b[i] = (tr < x[i]);
        1:       b[i] = 1'b1;
        default: b[i] = (i == 3) && (t % 2 == 0);
      endcase
    end
    return b;
  endfunction

  task automatic drive_window(input int n_hi, input int mode, input lanes_t x);
    for (int t = 0; t < n_hi; t++) begin
      @(posedge clk); #1;
      bus.i_isgen  = 1'b1;
      bus.i_sn_bit = gen_bits(mode, t, x);
    end
    @(posedge clk); #1;
    bus.i_isgen  = 1'b0;
    bus.i_sn_bit = '0;
  endtask

  // Scoreboard monitor: pop on o_valid, and otherwise require outputs to hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_valid) begin
        chk1("valid_single_cycle", prev_valid, 1'b0);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got o_valid=1 expected no pending window");
        end else begin
          sb_e = sb_q.pop_front();
          chk("x_bn", bus.o_x_bn, sb_e.x);
          chk1("trunc", bus.o_trunc, sb_e.trunc);
        end
      end else begin
        chk("x_bn_hold", bus.o_x_bn, prev_x);
        chk1("trunc_hold", bus.o_trunc, prev_trunc);
      end
    end
    prev_x     = bus.o_x_bn;
    prev_trunc = bus.o_trunc;
    prev_valid = bus.o_valid;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000ns");
    $fatal(1, "timeout");
  end

  vec_t   vt[8];
  lanes_t x1;
  lanes_t e6;

  initial begin
    x1 = {8'd254, 8'd99, 8'd7, 8'd200, 8'd64, 8'd128, 8'd1, 8'd255, 8'd0, 8'd165};
    e6 = '0;
    e6[3] = 8'd128;
    vt[0] = '{n_hi:256, mode:0, x:x1,          exp_x:x1,          exp_trunc:1'b0};
    vt[1] = '{n_hi:100, mode:1, x:'0,          exp_x:splat(100),  exp_trunc:1'b1};
    vt[2] = '{n_hi:256, mode:0, x:splat(10),   exp_x:splat(10),   exp_trunc:1'b0};
    vt[3] = '{n_hi:256, mode:0, x:splat(200),  exp_x:splat(200),  exp_trunc:1'b0};
    vt[4] = '{n_hi:256, mode:2, x:'0,          exp_x:e6,          exp_trunc:1'b0};
    vt[5] = '{n_hi:255, mode:1, x:'0,          exp_x:splat(255),  exp_trunc:1'b1};
    vt[6] = '{n_hi:256, mode:0, x:splat(255),  exp_x:splat(255),  exp_trunc:1'b0};
    vt[7] = '{n_hi:1,   mode:1, x:'0,          exp_x:splat(1),    exp_trunc:1'b1};

    bus.i_isgen  = 1'b0;
    bus.i_sn_bit = '0;
    #2;
    chk("rst_x_bn", bus.o_x_bn, '0);
    chk1("rst_valid", bus.o_valid, 1'b0);
    chk1("rst_trunc", bus.o_trunc, 1'b0);
    chk1("rst_busy", bus.o_busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);

    // Table windows back to back, each separated by a single low i_isgen cycle.
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back('{x: vt[k].exp_x, trunc: vt[k].exp_trunc});
      drive_window(vt[k].n_hi, vt[k].mode, vt[k].x);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain_table", lanes_t'(sb_q.size()), '0);

    // Reset 50 samples into a window: the partial count is discarded and outputs clear at once.
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      bus.i_isgen  = 1'b1;
      bus.i_sn_bit = gen_bits(1, t, '0);
    end
    @(posedge clk); #1;
    rst_n        = 1'b0;
    bus.i_isgen  = 1'b0;
    bus.i_sn_bit = '0;
    #1;
    chk("midrst_x_bn", bus.o_x_bn, '0);
    chk1("midrst_valid", bus.o_valid, 1'b0);
    chk1("midrst_trunc", bus.o_trunc, 1'b0);
    chk1("midrst_busy", bus.o_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    sb_q.push_back('{x: splat(42), trunc: 1'b0});
    drive_window(256, 0, splat(42));

    // 300 all-ones samples: one saturated result after sample 256, then HOLD until i_isgen falls.
    sb_q.push_back('{x: splat(255), trunc: 1'b0});
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (t == 256) chk1("sat_valid_at_256", bus.o_valid, 1'b1);
      if (t == 257) chk1("sat_valid_drop", bus.o_valid, 1'b0);
      if (t == 299) chk1("sat_busy_hold", bus.o_busy, 1'b1);
      bus.i_isgen  = 1'b1;
      bus.i_sn_bit = '1;
    end
    @(posedge clk); #1;
    bus.i_isgen  = 1'b0;
    bus.i_sn_bit = '0;
    chk1("sat_busy_before_fall", bus.o_busy, 1'b1);
    @(posedge clk); #1;
    chk1("sat_busy_after_fall", bus.o_busy, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain_end", lanes_t'(sb_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
